// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port frame-buffer RAM between camera
// writes (queued in a small FIFO) and VGA display reads (strict priority).
module fb_port_arbiter #(
    parameter int H_SRC = 320,
    parameter int V_SRC = 240,
    parameter int SHIFT = 1,
    parameter int AW    = 17,
    parameter int DW    = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     video_on,
    input  logic [11:0]              pixel_x,
    input  logic [11:0]              pixel_y,
    input  logic                     wr_valid,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    output logic                     wr_ready,
    output logic                     wr_drop,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic [DW-1:0]            mem_rdata,
    output logic [DW-1:0]            pix_data,
    output logic                     pix_valid,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [11:0] X_MASK = 12'((1 << SHIFT) - 1);
    localparam logic [11:0] X_MAX  = 12'(H_SRC - 1);
    localparam logic [11:0] Y_MAX  = 12'(V_SRC - 1);
    localparam logic [AW:0] N_PIX  = (AW + 1)'(H_SRC * V_SRC);
    localparam logic [PW:0] FULL   = (PW + 1)'(DEPTH);

    logic [AW+DW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      level;
    logic             rd_need;
    logic             in_range;
    logic             push;
    logic             pop;
    logic [11:0]      src_x;
    logic [11:0]      src_y;
    logic [AW-1:0]    rd_addr;
    logic             rd_pend;
    logic             vo_d1;
    logic             vo_d2;
    logic [DW-1:0]    hold;
    logic [DW-1:0]    pix_next;

    // Slot decision and clamped source address for this raster position
    always_comb begin
        rd_need  = video_on && ((pixel_x & X_MASK) == 12'd0);
        src_x    = pixel_x >> SHIFT;
        src_y    = pixel_y >> SHIFT;
        if (src_x > X_MAX) src_x = X_MAX;
        if (src_y > Y_MAX) src_y = Y_MAX;
        rd_addr  = AW'(src_y) * AW'(H_SRC) + AW'(src_x);
        wr_ready = !rst && (level < FULL);
        in_range = {1'b0, wr_addr} < N_PIX;
        push     = wr_valid && wr_ready && in_range;
        pop      = !rd_need && (level != '0);
        pix_next = rd_pend ? mem_rdata : hold;
    end

    assign fifo_level = level;

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {wr_addr, wr_data};
    end

    // FIFO pointers, occupancy and drop pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            wr_drop <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level   <= level + {{PW{1'b0}}, push}
                             - {{PW{1'b0}}, pop};
            wr_drop <= wr_valid && wr_ready && !in_range;
        end
    end

    // Registered RAM command: read, write from FIFO head, or idle
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (rd_need) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_addr;
        end else if (pop) begin
            mem_en                <= 1'b1;
            mem_we                <= 1'b1;
            {mem_addr, mem_wdata} <= fifo_mem[rd_ptr];
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    // Read return: capture RAM data, repeat it on non-read cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            vo_d1     <= 1'b0;
            vo_d2     <= 1'b0;
            hold      <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            rd_pend   <= mem_en && !mem_we;
            vo_d1     <= video_on;
            vo_d2     <= vo_d1;
            hold      <= pix_next;
            pix_valid <= vo_d2;
            pix_data  <= vo_d2 ? pix_next : '0;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed and random stimulus against a queue-based
// model of the frame buffer, write FIFO and display pipeline.
module tb_fb_port_arbiter;

    localparam int H_SRC = 320;
    localparam int V_SRC = 240;
    localparam int SHIFT = 1;
    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int DEPTH = 4;
    localparam int NPIX  = H_SRC * V_SRC;
    localparam int NW    = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          video_on;
    logic [11:0]   pixel_x;
    logic [11:0]   pixel_y;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          wr_drop;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic [2:0]    fifo_level;

    fb_port_arbiter #(
        .H_SRC(H_SRC), .V_SRC(V_SRC), .SHIFT(SHIFT),
        .AW(AW), .DW(DW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_drop(wr_drop),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pix_data(pix_data),
        .pix_valid(pix_valid), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Frame-buffer RAM, preloaded with addr = data
    logic [DW-1:0] ram [NW];
    bit            ram_init;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < NW; i++) ram[i] <= DW'(i);
            ram_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] img [NW];
    int            q_a[$];
    int            q_d[$];
    bit            pq_vo[$];
    logic [DW-1:0] pq_val[$];
    logic [DW-1:0] last_rd;
    int            last_addr;
    int            last_wd;
    bit            last_acc;
    logic [DW-1:0] obs_pix[$];
    bit            obs_drop;
    int            n_tests;
    int            n_fail;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit vo, input int x, input int y,
                        input bit wv, input int wa, input int wd);
        bit need, pop, acc, inr, pv;
        int sx, sy, ea, pa, pd;
        logic [DW-1:0] pval;
        rst = r; video_on = vo;
        pixel_x = 12'(x); pixel_y = 12'(y);
        wr_valid = wv; wr_addr = AW'(wa); wr_data = DW'(wd);
        #1;
        check("wr_ready", 32'(wr_ready), 32'(!r && q_a.size() < DEPTH));
        acc  = wv && !r && (q_a.size() < DEPTH);
        inr  = wa < NPIX;
        need = !r && vo && (x % (1 << SHIFT)) == 0;
        sx = x >> SHIFT;
        sy = y >> SHIFT;
        if (sx > H_SRC - 1) sx = H_SRC - 1;
        if (sy > V_SRC - 1) sy = V_SRC - 1;
        ea  = sy * H_SRC + sx;
        pop = !r && !need && q_a.size() > 0;
        pa = 0; pd = 0;
        if (r) begin
            q_a.delete(); q_d.delete();
            pq_vo.delete(); pq_val.delete();
            repeat (2) begin pq_vo.push_back(1'b0); pq_val.push_back('0); end
            last_rd = '0;
        end else begin
            if (need) last_rd = img[ea];
            if (pop) begin
                pa = q_a.pop_front();
                pd = q_d.pop_front();
                img[pa] = DW'(pd);
            end
            if (acc && inr) begin
                q_a.push_back(wa);
                q_d.push_back(wd % (1 << DW));
            end
        end
        pq_vo.push_back(!r && vo);
        pq_val.push_back((!r && vo) ? last_rd : '0);
        last_acc = acc;
        @(posedge clk); #1;
        if (r) begin
            last_addr = 0; last_wd = 0;
            check("rst_en", 32'(mem_en), 0);
            check("rst_we", 32'(mem_we), 0);
            check("rst_addr", 32'(mem_addr), 0);
            check("rst_wdata", 32'(mem_wdata), 0);
        end else if (need) begin
            check("rd_en", 32'(mem_en), 1);
            check("rd_we", 32'(mem_we), 0);
            check("rd_addr", 32'(mem_addr), 32'(ea));
            last_addr = ea;
        end else if (pop) begin
            check("wr_en", 32'(mem_en), 1);
            check("wr_we", 32'(mem_we), 1);
            check("wr_addr", 32'(mem_addr), 32'(pa));
            check("wr_data", 32'(mem_wdata), 32'(pd));
            last_addr = pa; last_wd = pd;
        end else begin
            check("idle_en", 32'(mem_en), 0);
            check("idle_we", 32'(mem_we), 0);
            check("idle_addr", 32'(mem_addr), 32'(last_addr));
            check("idle_wdata", 32'(mem_wdata), 32'(last_wd));
        end
        check("wr_drop", 32'(wr_drop), 32'(!r && acc && !inr));
        check("level", 32'(fifo_level), 32'(q_a.size()));
        pv   = pq_vo.pop_front();
        pval = pq_val.pop_front();
        check("pix_valid", 32'(pix_valid), 32'(pv));
        check("pix_data", 32'(pix_data), 32'(pval));
        obs_drop = wr_drop;
        if (pix_valid) obs_pix.push_back(pix_data);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 700, 500, 0, 0, 0);
    endtask

    initial begin
        int n;
        n_tests = 0; n_fail = 0;
        last_rd = '0; last_addr = 0; last_wd = 0;
        for (int i = 0; i < NW; i++) img[i] = DW'(i);

        // reset, then idle raster
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        idle(4);
        check("idle_ready_c", 32'(wr_ready), 1);
        check("idle_level_c", 32'(fifo_level), 0);
        check("idle_memen_c", 32'(mem_en), 0);

        // active line y=6, x=0..7
        obs_pix.delete();
        for (int x = 0; x < 8; x++) step(0, 1, x, 6, 0, 0, 0);
        idle(3);
        check("line_count", 32'(obs_pix.size()), 8);
        for (int i = 0; i < 8 && i < obs_pix.size(); i++)
            check("line_pix", 32'(obs_pix[i]), 32'(960 + i / 2));

        // burst of 6 writes against a read every cycle, then drain
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 2 * i, 10, 1, 200 + n, 'h100 + n);
            if (last_acc) n++;
        end
        check("burst_acc", 32'(n), 4);
        check("burst_ready", 32'(wr_ready), 0);
        check("burst_level", 32'(fifo_level), 4);
        for (int x = 12; x < 24; x++) begin
            step(0, 1, x, 10, n < 6, 200 + n, 'h100 + n);
            if (last_acc) n++;
        end
        check("burst_all", 32'(n), 6);
        idle(8);

        // out-of-range write is dropped
        step(0, 0, 700, 500, 1, NPIX, 'h555);
        check("drop_pulse", 32'(obs_drop), 1);
        check("drop_level", 32'(fifo_level), 0);
        idle(1);
        check("drop_once", 32'(obs_drop), 0);

        // write during blanking, then display it
        step(0, 0, 700, 500, 1, 5 * H_SRC + 7, 'hABC);
        idle(2);
        obs_pix.delete();
        step(0, 1, 14, 10, 0, 0, 0);
        idle(3);
        check("wr_rd_count", 32'(obs_pix.size()), 1);
        if (obs_pix.size() > 0)
            check("wr_rd_pix", 32'(obs_pix[0]), 'hABC);

        // reset with queued writes and reads in flight
        for (int i = 0; i < 3; i++)
            step(0, 1, 2 * i, 20, 1, 300 + i, 'h200 + i);
        check("pre_rst_level", 32'(fifo_level), 3);
        step(1, 1, 6, 20, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1 + 2 * i, 20, 0, 0, 0);
        check("post_rst_level", 32'(fifo_level), 0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bit r, vo, wv;
            int x, y, wa;
            r  = ($urandom_range(0, 399) == 0);
            vo = ($urandom_range(0, 3) != 0);
            x  = (c < 2000) ? (c % 800) : $urandom_range(0, 799);
            y  = $urandom_range(0, 524);
            wv = $urandom_range(0, 1);
            wa = ($urandom_range(0, 15) == 0) ? $urandom_range(NPIX, NW - 1)
                                              : $urandom_range(0, NPIX - 1);
            step(r, vo, x, y, wv, wa, $urandom_range(0, 4095));
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
